// File: rtl/pipe_perf_monitor_pkg.sv
// Shared definitions for the CPU run monitor: state encoding, counter width default
// and the rule deciding which hazard holds count as stalls.
package pipe_perf_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mon_state_e;

    localparam int unsigned CntWDefault = 32;

    // Holds caused by a jump or branch are control hazards, not data stalls.
    function automatic logic stall_qualified(input logic stall, input logic jump,
                                             input logic branch);
        return stall & ~jump & ~branch;
    endfunction

endpackage

// File: rtl/pipe_perf_monitor_trace_buf.sv
// pc_trace_buf: circular trace of the most recent distinct PC values with a
// registered indexed read (index 0 is the newest entry).
module pc_trace_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IdxW  = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            wr_en_i,
    input  logic [31:0]     pc_i,
    input  logic [IdxW-1:0] rd_idx_i,
    output logic [31:0]     rd_pc_o,
    output logic [IdxW:0]   count_o
);

    logic [31:0]     mem_q [DEPTH];
    logic [IdxW-1:0] wr_ptr_q;
    logic [IdxW:0]   count_q;
    logic [31:0]     rd_pc_q;

    logic [IdxW-1:0] newest_ptr;
    logic [IdxW-1:0] rd_ptr;
    logic            do_write;
    logic            rd_valid;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign newest_ptr = wr_ptr_q - IdxW'(1);
    assign rd_ptr     = wr_ptr_q - IdxW'(1) - rd_idx_i;
    assign do_write   = wr_en_i && ((count_q == '0) || (pc_i != mem_q[newest_ptr]));
    assign rd_valid   = {1'b0, rd_idx_i} < count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_pc_q  <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_pc_q  <= '0;
        end else begin
            // Read samples pre-write contents on a simultaneous write.
            rd_pc_q <= rd_valid ? mem_q[rd_ptr] : 32'd0;
            if (do_write) begin
                mem_q[wr_ptr_q] <= pc_i;
                wr_ptr_q        <= wr_ptr_q + IdxW'(1);
                if (count_q != (IdxW + 1)'(DEPTH)) count_q <= count_q + (IdxW + 1)'(1);
            end
        end
    end

    assign rd_pc_o = rd_pc_q;
    assign count_o = count_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Run monitor: counts run cycles, qualified stalls and flushes over a fixed cycle
// budget and keeps a trace of recent distinct PCs.
module pipe_perf_monitor
    import pipe_perf_monitor_pkg::*;
#(
    parameter int unsigned CYCLE_LIMIT = 30,
    parameter int unsigned CNT_W       = CntWDefault,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           clear_i,
    input  logic                           stall_i,
    input  logic                           jump_i,
    input  logic                           branch_i,
    input  logic                           flush_i,
    input  logic [31:0]                    pc_i,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
    output logic [CNT_W-1:0]               cycle_cnt_o,
    output logic [CNT_W-1:0]               stall_cnt_o,
    output logic [CNT_W-1:0]               flush_cnt_o,
    output logic                           running_o,
    output logic                           done_o,
    output logic [31:0]                    trace_pc_o,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count_o
);

    localparam int unsigned IdxW = $clog2(TRACE_DEPTH);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             active;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign active = (state_q == StRun) && start_i && !clear_i;

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (clear_i) begin
            state_d = StIdle;
            cycle_d = '0;
            stall_d = '0;
            flush_d = '0;
        end else begin
            unique case (state_q)
                StIdle: if (start_i) state_d = StRun;
                StRun: begin
                    if (start_i) begin
                        cycle_d = sat_inc(cycle_q);
                        if (stall_qualified(stall_i, jump_i, branch_i)) stall_d = sat_inc(stall_q);
                        if (flush_i) flush_d = sat_inc(flush_q);
                        if (cycle_d == CNT_W'(CYCLE_LIMIT)) state_d = StDone;
                    end
                end
                StDone: state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
        running_d = (state_d == StRun);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cycle_q   <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    pc_trace_buf #(
        .DEPTH (TRACE_DEPTH),
        .IdxW  (IdxW)
    ) u_trace (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .wr_en_i  (active),
        .pc_i     (pc_i),
        .rd_idx_i (trace_idx_i),
        .rd_pc_o  (trace_pc_o),
        .count_o  (trace_count_o)
    );

    assign cycle_cnt_o = cycle_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
    assign running_o   = running_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based behavioural model.
module tb_pipe_perf_monitor;

    localparam int Limit = 30;
    localparam int Depth = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, clear = 1'b0, stall = 1'b0, jump = 1'b0;
    logic        branch = 1'b0, flush = 1'b0;
    logic [31:0] pc = '0;
    logic [2:0]  idx = '0;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt, trace_pc;
    logic        running, done;
    logic [3:0]  trace_count;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Behavioural model: mode 0=idle 1=run 2=done; trace newest at index 0.
    int          m_mode = 0;
    int          m_cyc = 0, m_stall = 0, m_flush = 0;
    int unsigned m_tpc = 0;
    int unsigned trq[$];

    pipe_perf_monitor #(
        .CYCLE_LIMIT (Limit),
        .CNT_W       (32),
        .TRACE_DEPTH (Depth)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .clear_i       (clear),
        .stall_i       (stall),
        .jump_i        (jump),
        .branch_i      (branch),
        .flush_i       (flush),
        .pc_i          (pc),
        .trace_idx_i   (idx),
        .cycle_cnt_o   (cycle_cnt),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt),
        .running_o     (running),
        .done_o        (done),
        .trace_pc_o    (trace_pc),
        .trace_count_o (trace_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_tpc = 0;
                trq.delete();
            end else if (clear) begin
                m_mode = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_tpc = 0;
                trq.delete();
            end else begin
                m_tpc = (int'(idx) < trq.size()) ? trq[idx] : 0;
                if (m_mode == 0) begin
                    if (start) m_mode = 1;
                end else if (m_mode == 1 && start) begin
                    m_cyc++;
                    if (stall && !jump && !branch) m_stall++;
                    if (flush) m_flush++;
                    if (trq.size() == 0 || pc != trq[0]) begin
                        trq.push_front(pc);
                        if (trq.size() > Depth) void'(trq.pop_back());
                    end
                    if (m_cyc == Limit) m_mode = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cycle_cnt", cycle_cnt, m_cyc);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
            chk("running", {31'd0, running}, {31'd0, m_mode == 1});
            chk("done", {31'd0, done}, {31'd0, m_mode == 2});
            chk("trace_pc", trace_pc, m_tpc);
            chk("trace_count", {28'd0, trace_count}, trq.size());
        end
    end

    initial begin
        int n;
        repeat (2) step();
        rst = 1'b0;
        check_en = 1'b1;
        chk("reset_cycle", cycle_cnt, 0);
        chk("reset_running", {31'd0, running}, 0);

        // Full run with no events.
        step();
        start = 1'b1;
        step();
        chk("run_entered", {31'd0, running}, 1);
        chk("first_cycle_uncounted", cycle_cnt, 0);
        repeat (29) step();
        chk("done_not_early", {31'd0, done}, 0);
        step();
        chk("done_rise", {31'd0, done}, 1);
        chk("running_fall", {31'd0, running}, 0);
        chk("limit_cycle", cycle_cnt, 30);
        chk("no_stalls", stall_cnt, 0);
        chk("no_flushes", flush_cnt, 0);
        repeat (5) step();
        chk("hold_cycle", cycle_cnt, 30);

        // Clear with start in DONE: IDLE first, then RUN.
        clear = 1'b1;
        step();
        chk("clear_idle_run", {31'd0, running}, 0);
        chk("clear_idle_done", {31'd0, done}, 0);
        chk("clear_zero", cycle_cnt, 0);
        clear = 1'b0;
        step();
        chk("clear_then_run", {31'd0, running}, 1);
        chk("clear_then_cnt", cycle_cnt, 0);

        // Stall qualification and overlapping flush.
        stall = 1'b1; step();
        branch = 1'b1; step();
        branch = 1'b0; flush = 1'b1; step();
        stall = 1'b0; step();
        flush = 1'b0;
        chk("stall_qual", stall_cnt, 2);
        chk("flush_cnt2", flush_cnt, 2);

        // Repeated PCs are not traced.
        restart();
        foreach (trq[i]) ;
        begin
            int unsigned seq[6] = '{0, 4, 8, 8, 8, 12};
            foreach (seq[i]) begin pc = seq[i]; step(); end
        end
        chk("trace_count4", {28'd0, trace_count}, 4);
        begin
            int unsigned expv[4] = '{12, 8, 4, 0};
            for (int k = 0; k < 4; k++) begin
                idx = 3'(k);
                step();
                chk("trace_read", trace_pc, expv[k]);
            end
        end
        idx = 3'd5; step();
        chk("trace_read_oob", trace_pc, 0);

        // Wrap-around with 11 distinct PCs.
        restart();
        for (int i = 0; i <= 10; i++) begin pc = 32'(4 * i); step(); end
        chk("trace_full", {28'd0, trace_count}, 8);
        idx = 3'd0; step();
        chk("wrap_newest", trace_pc, 40);
        idx = 3'd7; step();
        chk("wrap_oldest", trace_pc, 12);

        // start_i low mid-run freezes everything.
        restart();
        idx = 3'd0;
        for (int i = 0; i < 10; i++) begin pc = 32'(100 + 4 * i); step(); end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin pc = 32'(500 + i); step(); end
        chk("freeze_running", {31'd0, running}, 1);
        chk("freeze_cycle", cycle_cnt, 10);
        chk("freeze_trace", trace_pc, 136);
        start = 1'b1;
        n = 0;
        while (!done && n < 40) begin step(); n++; end
        chk("resume_cycle", cycle_cnt, 30);
        chk("resume_steps", n, 20);

        // Asynchronous reset mid-run.
        restart();
        repeat (17) step();
        chk("pre_reset_cycle", cycle_cnt, 17);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_cycle", cycle_cnt, 0);
        chk("async_rst_running", {31'd0, running}, 0);
        chk("async_rst_count", {28'd0, trace_count}, 0);
        step();
        rst = 1'b0;

        // Randomized phase.
        for (int c = 0; c < 4000; c++) begin
            start  = ($urandom_range(0, 7) != 0);
            clear  = ($urandom_range(0, 39) == 0);
            stall  = $urandom_range(0, 1);
            jump   = ($urandom_range(0, 3) == 0);
            branch = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 2) == 0);
            idx    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: pc = pc + 32'd4;
                1: pc = 32'(4 * $urandom_range(0, 15));
                default: pc = pc;
            endcase
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
